ahb_resp_mux: RTL and testbench
===============================

# ahb_resp_mux

AHB-Lite slave-to-master response multiplexer with a built-in default slave. It sits in the interconnect between the address decoder and the single bus master. It registers the decoder's HSEL vector during the address phase, steers HRDATA/HREADY/HRESP from the selected slave during the data phase, and answers transfers to unmapped addresses with the standard two-cycle ERROR response. Its HREADY output is the system HREADY, fed back to the master and to every slave.

## Interface
- DATA_WIDTH, 32, width of all read-data buses
- DEFAULT_RDATA, 32'h0000_0000, HRDATA value driven when no slave owns the data phase
- CNT_WIDTH, 16, width of the unmapped-access counter
- HCLK  in  1  bus clock; all state updates on rising edge
- HRESET  in  1  reset, synchronous, active-high
- HSEL  in  4  one-hot slave select from address decoder (bit0 ROM, bit1 RAM, bit2 GPIO, bit3 Timer)
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- HRDATA_S0..HRDATA_S3  in  DATA_WIDTH each  slave read data
- HREADYOUT_S0..HREADYOUT_S3  in  1 each  slave ready
- HRESP_S0..HRESP_S3  in  1 each  slave response (0 OKAY, 1 ERROR)
- HRDATA  out  DATA_WIDTH  read data to master
- HREADY  out  1  system ready to master and all slaves
- HRESP  out  1  response to master
- UNMAPPED_CNT  out  CNT_WIDTH  saturating count of ERROR responses issued by default slave

## Operation
- Data-phase select register sel_q (one-hot over S0..S3, DEF, NONE) updates only on edges where HREADY=1; held otherwise.
- Update rule at HREADY=1:
  - any HSEL bit set -> lowest set index, regardless of HTRANS;
  - HSEL=0 and HTRANS[1]=1 -> DEF;
  - HSEL=0 and HTRANS[1]=0 -> NONE.
- Multiple HSEL bits set: lowest index wins, no error.
- Data-phase output mux:
  - sel_q=Sn -> HRDATA=HRDATA_Sn, HREADY=HREADYOUT_Sn, HRESP=HRESP_Sn;
  - sel_q=NONE -> HRDATA=DEFAULT_RDATA, HREADY=1, HRESP=0;
  - sel_q=DEF -> HRDATA=DEFAULT_RDATA, HREADY/HRESP from default-slave FSM.
- Default-slave FSM states:
  - DS_IDLE: HREADY=1, HRESP=0.
  - DS_ERR1: HREADY=0, HRESP=1.
  - DS_ERR2: HREADY=1, HRESP=1.
- FSM transitions:
  - DS_IDLE -> DS_ERR1 on an edge where HREADY=1, HSEL=0 and HTRANS[1]=1 (same edge that loads sel_q=DEF).
  - DS_ERR1 -> DS_ERR2 unconditionally.
  - DS_ERR2 -> DS_ERR1 if a new unmapped active transfer is sampled, else DS_IDLE.
- UNMAPPED_CNT increments by 1 on each DS_ERR1 entry and saturates at all-ones (no wrap).
- Routed slaves receive IDLE/BUSY via their own HSEL and answer zero-wait OKAY themselves; the mux only forwards their response.

## Timing
- Reset (HRESET=1 at an edge): sel_q=NONE, FSM=DS_IDLE, UNMAPPED_CNT=0, so HRDATA=DEFAULT_RDATA, HREADY=1, HRESP=0 from the following cycle.
- Reset mid-ERROR: the FSM abandons the response and returns to DS_IDLE; no ERR2 cycle is emitted.
- Outputs are combinational from sel_q, FSM state and slave inputs; no added latency. Slave wait states pass through cycle-for-cycle.
- An address phase presented while HREADY=0 is not sampled. The master holds it; it is sampled on the first edge with HREADY=1.
- An unmapped access costs exactly 2 data-phase cycles: ERR1 with HREADY low, then ERR2 with HREADY high.
- Back-to-back unmapped accesses give the pattern ERR1, ERR2, ERR1, ERR2. The counter increments once per access.

## Test plan
- Reset: hold HRESET 2 cycles -> HREADY=1, HRESP=0, HRDATA=0, UNMAPPED_CNT=0.
- RAM read: HSEL=4'b0010, HTRANS=NONSEQ; next cycle HRDATA_S1=32'h1234_5678, HREADYOUT_S1=1 -> HRDATA=32'h1234_5678, HREADY=1, HRESP=0 in that data cycle.
- Wait-state pass-through: GPIO selected, HREADYOUT_S2 low 3 cycles -> HREADY low exactly 3 cycles; a new HSEL=4'b0001 presented meanwhile is not latched until HREADY=1.
- Unmapped: HSEL=0, HTRANS=NONSEQ -> next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1, then IDLE; UNMAPPED_CNT=1. Two back-to-back unmapped accesses -> ERR1, ERR2, ERR1, ERR2 and UNMAPPED_CNT=2.
- IDLE to unmapped: HSEL=0, HTRANS=IDLE -> zero-wait OKAY, counter unchanged. Overlap HSEL=4'b1010 -> S1 data routed.
- Reset during ERR1 -> HREADY=1, HRESP=0 the next cycle; counter cleared to 0.

Source files
------------

// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux
// AHB-Lite slave-to-master response multiplexer with built-in default slave.
// Registers the decoder's HSEL during the address phase, steers
// HRDATA/HREADY/HRESP from the selected slave in the data phase, and answers
// unmapped active transfers with the two-cycle ERROR response.
//
// Ports
//   HCLK, HRESET          bus clock, synchronous active-high reset
//   HSEL[3:0]             one-hot decoder select (S0 ROM, S1 RAM, S2 GPIO, S3 Timer)
//   HTRANS[1:0]           master transfer type
//   HRDATA_Sn             slave read data
//   HREADYOUT_Sn          slave ready
//   HRESP_Sn              slave response
//   HRDATA, HREADY, HRESP response to master (HREADY is the system HREADY)
//   UNMAPPED_CNT          saturating count of default-slave ERROR responses
//
// Default-slave FSM
//   state   | meaning
//   DS_IDLE | no error pending, HREADY=1 HRESP=0
//   DS_ERR1 | first ERROR cycle, HREADY=0 HRESP=1
//   DS_ERR2 | second ERROR cycle, HREADY=1 HRESP=1
module ahb_resp_mux #(
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_RDATA = '0,
  parameter int                    CNT_WIDTH     = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [3:0]            HSEL,
  input  logic [1:0]            HTRANS,
  input  logic [DATA_WIDTH-1:0] HRDATA_S0,
  input  logic [DATA_WIDTH-1:0] HRDATA_S1,
  input  logic [DATA_WIDTH-1:0] HRDATA_S2,
  input  logic [DATA_WIDTH-1:0] HRDATA_S3,
  input  logic                  HREADYOUT_S0,
  input  logic                  HREADYOUT_S1,
  input  logic                  HREADYOUT_S2,
  input  logic                  HREADYOUT_S3,
  input  logic                  HRESP_S0,
  input  logic                  HRESP_S1,
  input  logic                  HRESP_S2,
  input  logic                  HRESP_S3,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [CNT_WIDTH-1:0]  UNMAPPED_CNT
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_t;

  // One-hot data-phase owner: bits 0..3 slaves, bit 4 default slave, bit 5 nobody
  localparam logic [5:0] SEL_S0   = 6'b000001;
  localparam logic [5:0] SEL_S1   = 6'b000010;
  localparam logic [5:0] SEL_S2   = 6'b000100;
  localparam logic [5:0] SEL_S3   = 6'b001000;
  localparam logic [5:0] SEL_DEF  = 6'b010000;
  localparam logic [5:0] SEL_NONE = 6'b100000;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [5:0]           sel_q;
  logic [5:0]           sel_d;
  ds_t                  ds_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 unmapped_req;
  logic                 htrans_unused;

  // HTRANS[0] (BUSY vs IDLE, SEQ vs NONSEQ) does not affect routing
  assign htrans_unused = HTRANS[0];

  // Active transfer to no slave, sampled only when the bus advances
  assign unmapped_req = HREADY && (HSEL == 4'b0000) && HTRANS[1];

  always_comb begin
    sel_d = sel_q;
    if (HREADY) begin
      if      (HSEL[0])   sel_d = SEL_S0;
      else if (HSEL[1])   sel_d = SEL_S1;
      else if (HSEL[2])   sel_d = SEL_S2;
      else if (HSEL[3])   sel_d = SEL_S3;
      else if (HTRANS[1]) sel_d = SEL_DEF;
      else                sel_d = SEL_NONE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_q <= SEL_NONE;
      ds_q  <= DS_IDLE;
      cnt_q <= '0;
    end else begin
      sel_q <= sel_d;
      unique case (ds_q)
        DS_IDLE: if (unmapped_req) ds_q <= DS_ERR1;
        DS_ERR1: ds_q <= DS_ERR2;
        DS_ERR2: ds_q <= unmapped_req ? DS_ERR1 : DS_IDLE;
        default: ds_q <= DS_IDLE;
      endcase
      // Every unmapped_req is an ERR1 entry; hold at all-ones
      if (unmapped_req && (cnt_q != '1)) cnt_q <= cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    HRDATA = DEFAULT_RDATA;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    case (sel_q)
      SEL_S0: begin HRDATA = HRDATA_S0; HREADY = HREADYOUT_S0; HRESP = HRESP_S0; end
      SEL_S1: begin HRDATA = HRDATA_S1; HREADY = HREADYOUT_S1; HRESP = HRESP_S1; end
      SEL_S2: begin HRDATA = HRDATA_S2; HREADY = HREADYOUT_S2; HRESP = HRESP_S2; end
      SEL_S3: begin HRDATA = HRDATA_S3; HREADY = HREADYOUT_S3; HRESP = HRESP_S3; end
      SEL_DEF: begin
        HREADY = (ds_q != DS_ERR1);
        HRESP  = (ds_q != DS_IDLE);
      end
      default: ;
    endcase
  end

  assign UNMAPPED_CNT = cnt_q;

endmodule

// File: tb/tb_ahb_resp_mux.sv
module tb_ahb_resp_mux;

  localparam int CW = 3;

  localparam logic [31:0] S0D = 32'h0000_AAAA;
  localparam logic [31:0] S1D = 32'h1234_5678;
  localparam logic [31:0] S2D = 32'h0000_2222;
  localparam logic [31:0] S3D = 32'h0000_3333;
  localparam logic [1:0]  IDLE   = 2'b00;
  localparam logic [1:0]  BUSY   = 2'b01;
  localparam logic [1:0]  NONSEQ = 2'b10;
  localparam logic [1:0]  SEQ    = 2'b11;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic [3:0]    HSEL;
  logic [1:0]    HTRANS;
  logic [31:0]   HRDATA_S0, HRDATA_S1, HRDATA_S2, HRDATA_S3;
  logic          HREADYOUT_S0, HREADYOUT_S1, HREADYOUT_S2, HREADYOUT_S3;
  logic          HRESP_S0, HRESP_S1, HRESP_S2, HRESP_S3;
  logic [31:0]   HRDATA;
  logic          HREADY;
  logic          HRESP;
  logic [CW-1:0] UNMAPPED_CNT;

  ahb_resp_mux #(
    .DATA_WIDTH(32),
    .DEFAULT_RDATA(32'h0000_0000),
    .CNT_WIDTH(CW)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS),
    .HRDATA_S0(HRDATA_S0), .HRDATA_S1(HRDATA_S1),
    .HRDATA_S2(HRDATA_S2), .HRDATA_S3(HRDATA_S3),
    .HREADYOUT_S0(HREADYOUT_S0), .HREADYOUT_S1(HREADYOUT_S1),
    .HREADYOUT_S2(HREADYOUT_S2), .HREADYOUT_S3(HREADYOUT_S3),
    .HRESP_S0(HRESP_S0), .HRESP_S1(HRESP_S1),
    .HRESP_S2(HRESP_S2), .HRESP_S3(HRESP_S3),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .UNMAPPED_CNT(UNMAPPED_CNT)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string         tag;
    logic [31:0]   rd;
    logic          rdy;
    logic          resp;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check_pop();
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      assert (HRDATA === e.rd) else begin
        miscompares++;
        $error("FAIL %s hrdata got %h exp %h", e.tag, HRDATA, e.rd);
      end
      vectors++;
      assert (HREADY === e.rdy) else begin
        miscompares++;
        $error("FAIL %s hready got %b exp %b", e.tag, HREADY, e.rdy);
      end
      vectors++;
      assert (HRESP === e.resp) else begin
        miscompares++;
        $error("FAIL %s hresp got %b exp %b", e.tag, HRESP, e.resp);
      end
      vectors++;
      assert (UNMAPPED_CNT === e.cnt) else begin
        miscompares++;
        $error("FAIL %s cnt got %0d exp %0d", e.tag, UNMAPPED_CNT, e.cnt);
      end
    end
  endtask

  // Drive this cycle's address phase (and S2 ready for the current data
  // phase), check the current data phase against the entry queued last
  // cycle, then queue what the next data phase must show.
  task automatic step(input logic rst, input logic [3:0] hsel,
                      input logic [1:0] htrans, input logic rdy2,
                      input string tag, input logic [31:0] rd,
                      input logic rdy, input logic resp, input logic [CW-1:0] cnt);
    exp_t e;
    HRESET       = rst;
    HSEL         = hsel;
    HTRANS       = htrans;
    HREADYOUT_S2 = rdy2;
    @(negedge HCLK);
    check_pop();
    e.tag = tag; e.rd = rd; e.rdy = rdy; e.resp = resp; e.cnt = cnt;
    sb.push_back(e);
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    logic [CW-1:0] c;
    HRESET = 1'b1; HSEL = 4'b0000; HTRANS = IDLE;
    HRDATA_S0 = S0D; HRDATA_S1 = S1D; HRDATA_S2 = S2D; HRDATA_S3 = S3D;
    HREADYOUT_S0 = 1'b1; HREADYOUT_S1 = 1'b1; HREADYOUT_S2 = 1'b1; HREADYOUT_S3 = 1'b1;
    HRESP_S0 = 1'b0; HRESP_S1 = 1'b0; HRESP_S2 = 1'b0; HRESP_S3 = 1'b0;
    @(posedge HCLK);
    #1;

    // reset held two cycles
    step(1, 4'b0000, IDLE,   1, "rst1",     32'h0, 1, 0, 0);
    step(1, 4'b0000, IDLE,   1, "rst2",     32'h0, 1, 0, 0);
    // RAM read
    step(0, 4'b0010, NONSEQ, 1, "ram",      S1D,   1, 0, 0);
    // GPIO with 3 wait states; ROM address held meanwhile
    step(0, 4'b0100, NONSEQ, 1, "gpio_w1",  S2D,   0, 0, 0);
    step(0, 4'b0001, NONSEQ, 0, "gpio_w2",  S2D,   0, 0, 0);
    step(0, 4'b0001, NONSEQ, 0, "gpio_w3",  S2D,   0, 0, 0);
    step(0, 4'b0001, NONSEQ, 0, "gpio_rdy", S2D,   1, 0, 0);
    step(0, 4'b0001, NONSEQ, 1, "rom",      S0D,   1, 0, 0);
    // single unmapped access
    step(0, 4'b0000, NONSEQ, 1, "err1a",    32'h0, 0, 1, 1);
    step(0, 4'b0000, IDLE,   1, "err2a",    32'h0, 1, 1, 1);
    step(0, 4'b0000, IDLE,   1, "idle_a",   32'h0, 1, 0, 1);
    // back-to-back unmapped accesses
    step(0, 4'b0000, NONSEQ, 1, "err1b",    32'h0, 0, 1, 2);
    step(0, 4'b0000, SEQ,    1, "err2b",    32'h0, 1, 1, 2);
    step(0, 4'b0000, NONSEQ, 1, "err1c",    32'h0, 0, 1, 3);
    step(0, 4'b0000, IDLE,   1, "err2c",    32'h0, 1, 1, 3);
    step(0, 4'b0000, IDLE,   1, "idle_b",   32'h0, 1, 0, 3);
    // BUSY to nobody: zero-wait OKAY, counter unchanged
    step(0, 4'b0000, BUSY,   1, "busy_ok",  32'h0, 1, 0, 3);
    // overlapping select, lowest index wins even for IDLE
    step(0, 4'b1010, IDLE,   1, "overlap",  S1D,   1, 0, 3);
    // reset during ERR1
    step(0, 4'b0000, NONSEQ, 1, "err1d",    32'h0, 0, 1, 4);
    step(1, 4'b0000, IDLE,   1, "rst_err",  32'h0, 1, 0, 0);
    step(0, 4'b1000, NONSEQ, 1, "timer",    S3D,   1, 0, 0);
    // counter saturation
    for (int i = 0; i < 9; i++) begin
      c = (i + 1 > 7) ? 3'd7 : 3'(i + 1);
      step(0, 4'b0000, NONSEQ, 1, "sat_err1", 32'h0, 0, 1, c);
      step(0, 4'b0000, NONSEQ, 1, "sat_err2", 32'h0, 1, 1, c);
    end
    step(0, 4'b0000, IDLE,   1, "sat_idle", 32'h0, 1, 0, 7);
    step(0, 4'b0000, IDLE,   1, "end_idle", 32'h0, 1, 0, 7);
    @(negedge HCLK);
    check_pop();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
